bs_mult_ctrl: RTL and testbench

BS_MULT_CTRL -- requirements
Module: bs_mult_ctrl

---
 rtl/bs_mult_ctrl_if.sv | 22 ++
 rtl/bs_mult_ctrl.sv | 109 ++++++++++
 tb/tb_bs_mult_ctrl.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/bs_mult_ctrl_if.sv
// Operand/product handshake bundle for the bit-serial multiplier controller.
interface bs_mult_ctrl_if #(
  parameter int W = 8
);
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] product;

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, product
  );

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, product
  );
endinterface

// File: rtl/bs_mult_ctrl.sv
// Bit-serial multiplier controller: streams two operands LSB first into an
// external slice chain, collects the serial product and presents it in parallel.
//
// state | meaning
// IDLE  | ready for an operand pair
// SHIFT | 2W cycles of serial operand bits, k = cnt
// DRAIN | LAT cycles collecting the remaining product bits
// HOLD  | product valid, waiting for out_ready
module bs_mult_ctrl #(
  parameter int W   = 8,
  parameter int LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  bs_mult_ctrl_if.slave bus,
  output logic          x_out,
  output logic          y_out,
  output logic          r_out,
  output logic          lastbit_out,
  input  logic          p_in
);

  localparam int NB = 2 * W;
  localparam int CW = $clog2(NB + LAT + 1);
  localparam logic [CW-1:0] K_LAST  = CW'(NB - 1);
  localparam logic [CW-1:0] D_LAST  = CW'(NB + LAT - 1);
  localparam logic [CW-1:0] S_FIRST = CW'(LAT);

  typedef enum logic [1:0] {IDLE, SHIFT, DRAIN, HOLD} state_t;

  state_t         state, state_nxt;
  logic [CW-1:0]  cnt;
  logic [W-1:0]   sa, sb;
  logic [NB-1:0]  prod;
  logic           sample;

  // State register; reset drops straight back to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode; the cycle counter spans SHIFT and DRAIN.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid)  state_nxt = SHIFT;
      SHIFT:   if (cnt == K_LAST) state_nxt = DRAIN;
      DRAIN:   if (cnt == D_LAST) state_nxt = HOLD;
      HOLD:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Product bit j arrives LAT cycles after operand bit j went out.
  assign sample = ((state == SHIFT) || (state == DRAIN)) && (cnt >= S_FIRST);

  // Operand shifters, registered serial outputs, counter and product capture.
  // Bit 0 is loaded into x_out/y_out at the accept edge so it is on the wire
  // during k=0; zeros shifting in give the zero extension for k >= W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      sa    <= '0;
      sb    <= '0;
      x_out <= 1'b0;
      y_out <= 1'b0;
      prod  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            sa    <= bus.a >> 1;
            sb    <= bus.b >> 1;
            x_out <= bus.a[0];
            y_out <= bus.b[0];
            cnt   <= '0;
            prod  <= '0;
          end
        end
        SHIFT: begin
          cnt <= cnt + CW'(1);
          if (cnt == K_LAST) begin
            x_out <= 1'b0;
            y_out <= 1'b0;
          end else begin
            x_out <= sa[0];
            y_out <= sb[0];
            sa    <= sa >> 1;
            sb    <= sb >> 1;
          end
        end
        DRAIN: cnt <= cnt + CW'(1);
        default: ;
      endcase
      if (sample) prod <= {p_in, prod[NB-1:1]};
    end
  end

  // Frame markers and handshake outputs; the product is only shown in HOLD.
  always_comb begin
    r_out         = (state == SHIFT) && (cnt == '0);
    lastbit_out   = (state == SHIFT) && (cnt == K_LAST);
    bus.in_ready  = (state == IDLE) && !rst;
    bus.out_valid = (state == HOLD);
    bus.product   = (state == HOLD) ? prod : '0;
  end

endmodule

// File: tb/tb_bs_mult_ctrl.sv
// Bench for bs_mult_ctrl: a LAT=1 and a LAT=4 instance, each fed by a
// behavioural serial multiplier that rebuilds the operands from the serial
// bits and returns product bits delayed by LAT cycles.
module tb_bs_mult_ctrl;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bs_mult_ctrl_if #(.W(W)) bus0 ();
  bs_mult_ctrl_if #(.W(W)) bus1 ();

  logic       iv   [2] = '{1'b0, 1'b0};
  logic       ordy [2] = '{1'b0, 1'b0};
  logic [7:0] av   [2] = '{8'd0, 8'd0};
  logic [7:0] bv   [2] = '{8'd0, 8'd0};

  wire [1:0]  x_o, y_o, r_o, l_o, ir, ov;
  wire [15:0] pr [2];
  logic [3:0] pipe [2] = '{4'd0, 4'd0};

  assign bus0.in_valid  = iv[0];
  assign bus0.a         = av[0];
  assign bus0.b         = bv[0];
  assign bus0.out_ready = ordy[0];
  assign bus1.in_valid  = iv[1];
  assign bus1.a         = av[1];
  assign bus1.b         = bv[1];
  assign bus1.out_ready = ordy[1];
  assign ir    = {bus1.in_ready, bus0.in_ready};
  assign ov    = {bus1.out_valid, bus0.out_valid};
  assign pr[0] = bus0.product;
  assign pr[1] = bus1.product;

  bs_mult_ctrl #(.W(W), .LAT(1)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0),
    .x_out(x_o[0]), .y_out(y_o[0]), .r_out(r_o[0]), .lastbit_out(l_o[0]),
    .p_in(pipe[0][0])
  );

  bs_mult_ctrl #(.W(W), .LAT(4)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1),
    .x_out(x_o[1]), .y_out(y_o[1]), .r_out(r_o[1]), .lastbit_out(l_o[1]),
    .p_in(pipe[1][3])
  );

  // Serial multiplier model: operands seen so far, product bit idx of their
  // plain product, delayed through a LAT-deep pipe.
  int unsigned mx [2] = '{0, 0};
  int unsigned my [2] = '{0, 0};
  int unsigned midx [2] = '{0, 0};

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      automatic int unsigned tx = r_o[d] ? 0 : mx[d];
      automatic int unsigned ty = r_o[d] ? 0 : my[d];
      automatic int unsigned ti = r_o[d] ? 0 : midx[d];
      automatic logic pb = 1'b0;
      if (ti < 16) begin
        tx = tx | (int'(x_o[d]) << ti);
        ty = ty | (int'(y_o[d]) << ti);
        pb = ((tx * ty) >> ti) & 1;
        ti = ti + 1;
      end
      mx[d]   <= tx;
      my[d]   <= ty;
      midx[d] <= ti;
      pipe[d] <= {pipe[d][2:0], pb};
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // One full transaction on instance d; entered and left near a negedge.
  task automatic txn(input int d, input logic [7:0] a, input logic [7:0] b, input int hold);
    automatic int lat = (d == 0) ? 1 : 4;
    automatic int n = 0;
    automatic logic [31:0] xs = 0, ys = 0, rs = 0, ls = 0, ovs = 0, irs = 0;
    automatic logic [15:0] p;
    automatic logic stab = 1'b0;
    while (!ir[d] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check_val("ready_timeout", n, 0);
    iv[d] = 1'b1;
    av[d] = a;
    bv[d] = b;
    @(posedge clk);
    #1;
    for (int c = 1; c <= 2*W + lat; c++) begin
      xs[c-1]  = x_o[d];
      ys[c-1]  = y_o[d];
      rs[c-1]  = r_o[d];
      ls[c-1]  = l_o[d];
      ovs[c-1] = ov[d];
      irs[c-1] = ir[d];
      iv[d]   = 1'($urandom_range(0, 1));
      av[d]   = 8'($urandom);
      bv[d]   = 8'($urandom);
      ordy[d] = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    iv[d]   = 1'b0;
    ordy[d] = 1'b0;
    check_val("x_bits", xs, {24'd0, a});
    check_val("y_bits", ys, {24'd0, b});
    check_val("r_mark", rs, 32'h1);
    check_val("last_mark", ls, 32'h8000);
    check_val("early_valid", ovs, 0);
    check_val("busy_ready", irs, 0);
    check_val("out_valid", ov[d], 1);
    check_val("product", pr[d], 32'(a) * 32'(b));
    p = pr[d];
    for (int h = 0; h < hold; h++) begin
      iv[d] = 1'($urandom_range(0, 1));
      av[d] = 8'($urandom);
      @(posedge clk);
      #1;
      stab = stab | (pr[d] != p) | !ov[d] | ir[d];
    end
    if (hold > 0) check_val("hold_stable", stab, 0);
    iv[d]   = 1'b0;
    ordy[d] = 1'b1;
    @(posedge clk);
    #1;
    ordy[d] = 1'b0;
    check_val("post_hs_valid", ov[d], 0);
    check_val("post_hs_ready", ir[d], 1);
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check_val("rst_outs0", {x_o[0], y_o[0], r_o[0], l_o[0], ov[0], ir[0]}, 0);
    check_val("rst_outs1", {x_o[1], y_o[1], r_o[1], l_o[1], ov[1], ir[1]}, 0);
    check_val("rst_prod", {pr[1], pr[0]}, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_val("ready_after_rst", ir, 2'b11);

    txn(0, 8'd3, 8'd5, 0);
    txn(0, 8'd255, 8'd255, 0);
    txn(0, 8'd0, 8'hA5, 0);
    txn(0, 8'($urandom), 8'($urandom), 10);

    // Abort at k=5 with an asynchronous reset pulse.
    iv[0] = 1'b1;
    av[0] = 8'($urandom_range(1, 255));
    bv[0] = 8'($urandom_range(1, 255));
    @(posedge clk);
    #1;
    iv[0] = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_val("abort_outs", {x_o[0], y_o[0], r_o[0], l_o[0], ov[0], ir[0]}, 0);
    check_val("abort_prod", pr[0], 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_val("abort_ready", ir[0], 1);
    txn(0, 8'd7, 8'd9, 0);

    for (int i = 0; i < 6; i++)
      txn(0, 8'($urandom), 8'($urandom), int'($urandom_range(0, 3)));

    txn(1, 8'd200, 8'd3, 0);
    txn(1, 8'd255, 8'd255, 2);
    for (int i = 0; i < 3; i++)
      txn(1, 8'($urandom), 8'($urandom), int'($urandom_range(0, 3)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
